// File: rtl/td4x_pkg.sv
// Shared opcode map and FSM encoding for the TD4X core.
package td4x_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StHalt  = 2'd2
    } state_e;

    localparam logic [3:0] OpAddA   = 4'b0000;
    localparam logic [3:0] OpMovAB  = 4'b0001;
    localparam logic [3:0] OpInA    = 4'b0010;
    localparam logic [3:0] OpMovAIm = 4'b0011;
    localparam logic [3:0] OpMovBA  = 4'b0100;
    localparam logic [3:0] OpAddB   = 4'b0101;
    localparam logic [3:0] OpInB    = 4'b0110;
    localparam logic [3:0] OpMovBIm = 4'b0111;
    localparam logic [3:0] OpSubA   = 4'b1000;
    localparam logic [3:0] OpOutB   = 4'b1001;
    localparam logic [3:0] OpHlt    = 4'b1010;
    localparam logic [3:0] OpOutIm  = 4'b1011;
    localparam logic [3:0] OpJz     = 4'b1100;
    localparam logic [3:0] OpNop    = 4'b1101;
    localparam logic [3:0] OpJnc    = 4'b1110;
    localparam logic [3:0] OpJmp    = 4'b1111;

endpackage

// File: rtl/td4x_alu.sv
// Combinational add/subtract unit; c is carry on add and borrow on subtract.
module td4x_alu #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y,
    output logic         c,
    output logic         z
);

    logic [N:0] sum;

    // Bit N of the widened difference is set exactly when a < b.
    always_comb begin
        if (sub) begin
            sum = {1'b0, a} - {1'b0, b};
        end else begin
            sum = {1'b0, a} + {1'b0, b};
        end
    end

    assign y = sum[N-1:0];
    assign c = sum[N];
    assign z = (sum[N-1:0] == '0);

endmodule

// File: rtl/td4x_core.sv
// TD4X processor core: fetch/exec/halt sequencer, PC, A/B registers, flags and output port.
module td4x_core
    import td4x_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [N+3:0]      D,
    input  logic              D_VALID,
    output logic [ADDR_W-1:0] A,
    output logic              FETCH,
    input  logic [N-1:0]      IN,
    output logic [N-1:0]      OUT,
    output logic              OUT_STB,
    output logic              HALTED
);

    if (N < 4 || N > 16) begin : gBadN
        $error("td4x_core: N must lie in 4..16");
    end
    if (ADDR_W > N) begin : gBadAddrW
        $error("td4x_core: ADDR_W must not exceed N");
    end

    state_e            state_q, state_d;
    logic [N+3:0]      ir_q;
    logic [ADDR_W-1:0] pc_q, pcNext;
    logic [N-1:0]      regA_q, regB_q, out_q;
    logic              c_q, z_q, outStb_q;

    logic [3:0]   op;
    logic [N-1:0] im;
    logic [N-1:0] aluA, aluY;
    logic         aluC, aluZ;

    assign op   = ir_q[N+3:N];
    assign im   = ir_q[N-1:0];
    assign aluA = (op == OpAddB) ? regB_q : regA_q;

    td4x_alu #(.N(N)) u_alu (
        .a   (aluA),
        .b   (im),
        .sub (op == OpSubA),
        .y   (aluY),
        .c   (aluC),
        .z   (aluZ)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: if (D_VALID) state_d = StExec;
            StExec:  state_d = (op == OpHlt) ? StHalt : StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        FETCH  = (state_q == StFetch);
        HALTED = (state_q == StHalt);
    end

    // Jump conditions use the flags as they stand before this instruction.
    always_comb begin
        pcNext = pc_q + ADDR_W'(1);
        case (op)
            OpJmp:   pcNext = im[ADDR_W-1:0];
            OpJnc:   if (!c_q) pcNext = im[ADDR_W-1:0];
            OpJz:    if (z_q) pcNext = im[ADDR_W-1:0];
            OpHlt:   pcNext = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            ir_q     <= '0;
            pc_q     <= '0;
            regA_q   <= '0;
            regB_q   <= '0;
            out_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            outStb_q <= 1'b0;
        end else begin
            outStb_q <= 1'b0;
            if (state_q == StFetch && D_VALID) begin
                ir_q <= D;
            end
            if (state_q == StExec) begin
                pc_q <= pcNext;
                case (op)
                    OpAddA, OpSubA: begin
                        regA_q <= aluY;
                        c_q    <= aluC;
                        z_q    <= aluZ;
                    end
                    OpAddB: begin
                        regB_q <= aluY;
                        c_q    <= aluC;
                        z_q    <= aluZ;
                    end
                    OpMovAIm: regA_q <= im;
                    OpMovBIm: regB_q <= im;
                    OpMovAB:  regA_q <= regB_q;
                    OpMovBA:  regB_q <= regA_q;
                    OpInA:    regA_q <= IN;
                    OpInB:    regB_q <= IN;
                    OpOutB: begin
                        out_q    <= regB_q;
                        outStb_q <= 1'b1;
                    end
                    OpOutIm: begin
                        out_q    <= im;
                        outStb_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign A       = pc_q;
    assign OUT     = out_q;
    assign OUT_STB = outStb_q;

endmodule

// File: tb/tb_td4x_core.sv
// Directed and randomized checks of td4x_core against an instruction-level reference model.
module tb_td4x_core;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int M  = 1 << N;
    localparam int PM = 1 << AW;

    logic          CLK = 1'b0;
    logic          CLR = 1'b1;
    logic [N+3:0]  D = '0;
    logic          D_VALID = 1'b0;
    logic [N-1:0]  IN = '0;
    logic [AW-1:0] A;
    logic [N-1:0]  OUT;
    logic          FETCH, OUT_STB, HALTED;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state, one step per instruction.
    int mPc, mA, mB, mC, mZ, mOut, mHalt;
    logic [7:0] prog [PM];

    td4x_core #(.N(N), .ADDR_W(AW)) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .D       (D),
        .D_VALID (D_VALID),
        .A       (A),
        .FETCH   (FETCH),
        .IN      (IN),
        .OUT     (OUT),
        .OUT_STB (OUT_STB),
        .HALTED  (HALTED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkArch(input string tag);
        chk({tag, "_pc"}, 32'(A), 32'(mPc));
        chk({tag, "_rega"}, 32'(dut.regA_q), 32'(mA));
        chk({tag, "_regb"}, 32'(dut.regB_q), 32'(mB));
        chk({tag, "_c"}, 32'(dut.c_q), 32'(mC));
        chk({tag, "_z"}, 32'(dut.z_q), 32'(mZ));
        chk({tag, "_out"}, 32'(OUT), 32'(mOut));
    endtask

    task automatic modelExec(input logic [7:0] ins, input int inVal, output bit strobe);
        int op;
        int im;
        int s;
        int nextPc;
        op     = int'(ins[7:4]);
        im     = int'(ins[3:0]);
        strobe = 1'b0;
        nextPc = (mPc + 1) % PM;
        case (op)
            0:  begin s = mA + im; mA = s % M; mC = s / M; mZ = (mA == 0); end
            5:  begin s = mB + im; mB = s % M; mC = s / M; mZ = (mB == 0); end
            8:  begin mC = (mA < im); mA = (mA - im + M) % M; mZ = (mA == 0); end
            3:  mA = im;
            7:  mB = im;
            1:  mA = mB;
            4:  mB = mA;
            2:  mA = inVal;
            6:  mB = inVal;
            9:  begin mOut = mB; strobe = 1'b1; end
            11: begin mOut = im; strobe = 1'b1; end
            15: nextPc = im % PM;
            14: if (mC == 0) nextPc = im % PM;
            12: if (mZ == 1) nextPc = im % PM;
            10: begin mHalt = 1; nextPc = mPc; end
            default: ;
        endcase
        mPc = nextPc;
    endtask

    task automatic runInstr(input logic [7:0] ins, input int stalls, input string tag);
        bit strobe;
        int inVal;
        chk({tag, "_infetch"}, 32'(FETCH), 32'd1);
        D       = ins;
        D_VALID = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            tick();
            chk({tag, "_stall_fetch"}, 32'(FETCH), 32'd1);
            chkArch({tag, "_stall"});
        end
        D_VALID = 1'b1;
        tick();
        chk({tag, "_exec_fetch"}, 32'(FETCH), 32'd0);
        chk({tag, "_exec_stb"}, 32'(OUT_STB), 32'd0);
        inVal   = int'($urandom_range(0, M - 1));
        IN      = N'(inVal);
        D       = 8'($urandom);
        D_VALID = 1'($urandom_range(0, 1));
        tick();
        modelExec(ins, inVal, strobe);
        chk({tag, "_halted"}, 32'(HALTED), 32'(mHalt));
        chk({tag, "_fetch"}, 32'(FETCH), 32'(mHalt == 0));
        chk({tag, "_stb"}, 32'(OUT_STB), 32'(strobe));
        chkArch(tag);
    endtask

    task automatic doReset(input string tag);
        CLR     = 1'b1;
        D_VALID = 1'b1;
        D       = 8'($urandom);
        tick();
        CLR     = 1'b0;
        D_VALID = 1'b0;
        mPc = 0; mA = 0; mB = 0; mC = 0; mZ = 0; mOut = 0; mHalt = 0;
        chk({tag, "_fetch"}, 32'(FETCH), 32'd1);
        chk({tag, "_halted"}, 32'(HALTED), 32'd0);
        chk({tag, "_stb"}, 32'(OUT_STB), 32'd0);
        chk({tag, "_ir"}, 32'(dut.ir_q), 32'd0);
        chkArch(tag);
    endtask

    initial begin
        doReset("rst");

        // Carry and zero from ADD, JNC not taken.
        runInstr(8'h3F, 0, "cz_mov");
        runInstr(8'h01, 0, "cz_add");
        runInstr(8'hE0, 0, "cz_jnc");
        chk("cz_rega_k", 32'(dut.regA_q), 32'h0);
        chk("cz_c_k", 32'(dut.c_q), 32'h1);
        chk("cz_z_k", 32'(dut.z_q), 32'h1);
        chk("cz_pc_k", 32'(A), 32'h3);

        // Borrow from SUB, JZ not taken.
        doReset("rst2");
        runInstr(8'h32, 0, "br_mov");
        runInstr(8'h83, 0, "br_sub");
        runInstr(8'hC0, 0, "br_jz");
        chk("br_rega_k", 32'(dut.regA_q), 32'hF);
        chk("br_c_k", 32'(dut.c_q), 32'h1);
        chk("br_z_k", 32'(dut.z_q), 32'h0);
        chk("br_pc_k", 32'(A), 32'h3);

        // Fetch stall at PC=5 with non-trivial architectural state.
        runInstr(8'h39, 0, "st_mov");
        runInstr(8'h08, 0, "st_add");
        runInstr(8'hF5, 0, "st_jmp");
        chk("st_pc5_k", 32'(A), 32'h5);
        runInstr(8'h77, 3, "st_stall");

        // Output strobes.
        runInstr(8'hBA, 0, "ob_outim");
        chk("ob_out_k", 32'(OUT), 32'hA);
        runInstr(8'h76, 0, "ob_movb");
        chk("ob_stb_gone", 32'(OUT_STB), 32'h0);
        runInstr(8'h90, 0, "ob_outb");
        chk("ob_out6_k", 32'(OUT), 32'h6);

        // PC wrap.
        runInstr(8'hFF, 0, "wr_jmp");
        runInstr(8'hD0, 0, "wr_nop");
        chk("wr_pc0_k", 32'(A), 32'h0);

        // Halt at PC=7, then CLR.
        runInstr(8'hF7, 0, "ht_jmp");
        runInstr(8'hA0, 0, "ht_hlt");
        D_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ht_halted", 32'(HALTED), 32'h1);
            chk("ht_fetch", 32'(FETCH), 32'h0);
            chk("ht_pc7", 32'(A), 32'h7);
            chkArch("ht_hold");
        end
        doReset("ht_clr");

        // CLR while an OUT is in EXEC must leave no trace.
        runInstr(8'h75, 0, "mx_movb");
        D       = 8'hB3;
        D_VALID = 1'b1;
        tick();
        chk("mx_inexec", 32'(FETCH), 32'h0);
        doReset("mx_clr");
        tick();
        chk("mx_stb_after", 32'(OUT_STB), 32'h0);
        chk("mx_out_after", 32'(OUT), 32'h0);

        // Random programs without HLT.
        for (int p = 0; p < 3; p++) begin
            doReset("rnd_rst");
            for (int k = 0; k < PM; k++) begin
                prog[k] = 8'($urandom);
                if (prog[k][7:4] == 4'b1010) prog[k] = 8'hD0;
            end
            for (int i = 0; i < 120; i++) begin
                runInstr(prog[mPc], int'($urandom_range(0, 2)), "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/td4x_core.md
TD4X_CORE -- requirements
Module: td4x_core

Interface
REQ-001 SHALL have parameter N, default 4: data/register/immediate width, legal range 4..16.
REQ-002 SHALL have parameter ADDR_W, default 4: program address width; elaboration error unless ADDR_W <= N.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port CLR  in  1  synchronous, active-high reset.
REQ-005 SHALL have port D  in  N+4  instruction word: D[N+3:N] opcode, D[N-1:0] immediate Im.
REQ-006 SHALL have port D_VALID  in  1  instruction memory has D valid for address A.
REQ-007 SHALL have port A  out  ADDR_W  program counter, drives instruction address.
REQ-008 SHALL have port FETCH  out  1  high in FETCH state; request to instruction memory.
REQ-009 SHALL have port IN  in  N  input port, sampled in EXEC.
REQ-010 SHALL have port OUT  out  N  registered output port.
REQ-011 SHALL have port OUT_STB  out  1  one-cycle pulse in the cycle after OUT is written.
REQ-012 SHALL have port HALTED  out  1  core is in HALT state.

Function
REQ-013 SHALL implement FSM FETCH/EXEC/HALT; FETCH->EXEC on D_VALID=1, latching D into internal IR; otherwise stay in FETCH with all architectural state held.
REQ-014 SHALL execute IR in EXEC in one cycle, then go to FETCH, or to HALT for HLT; minimum 2 cycles per instruction.
REQ-015 SHALL decode opcodes: 0000 ADD A,Im; 0101 ADD B,Im; 1000 SUB A,Im; 0011 MOV A,Im; 0111 MOV B,Im; 0001 MOV A,B; 0100 MOV B,A; 0010 IN A; 0110 IN B; 1001 OUT B; 1011 OUT Im; 1111 JMP Im; 1110 JNC Im; 1100 JZ Im; 1010 HLT; 1101 NOP.
REQ-016 SHALL compute ADD as (N+1)-bit sum: result = low N bits, C = bit N.
REQ-017 SHALL compute SUB as A - Im modulo 2^N, with C = 1 iff A < Im (borrow).
REQ-018 SHALL set Z = (result == 0) on ADD/SUB only; C and Z SHALL hold on every other opcode.
REQ-019 SHALL take jumps with PC <= Im[ADDR_W-1:0]: JMP always; JNC iff C=0; JZ iff Z=1. Flag values are those before the jump instruction executes.
REQ-020 SHALL otherwise advance PC by 1 modulo 2^ADDR_W in EXEC, so 2^ADDR_W-1 wraps to 0; HLT leaves PC unchanged.
REQ-021 SHALL register OUT on OUT B/OUT Im in EXEC and assert OUT_STB for exactly the following cycle.
REQ-022 SHALL stay in HALT indefinitely with FETCH=0, HALTED=1, and all registers held; exit only via CLR.
REQ-023 SHALL make CLR take priority over every event, including D_VALID, EXEC, and HALT.

Reset
REQ-024 SHALL, on CLR=1 at a rising edge, set A(PC)=0, register A=0, register B=0, OUT=0, C=0, Z=0, IR=0, OUT_STB=0, state=FETCH; FETCH=1 and HALTED=0 in the cycle after.
REQ-025 SHALL abandon any in-flight instruction when CLR occurs mid-EXEC, with no side effects from it.

Structure
REQ-026 SHALL keep opcode constants and the FSM state encoding in the shared td4x_pkg package.
REQ-027 SHALL instantiate one sub-module td4x_alu (parameter N; inputs a, b, sub; outputs y, c, z), purely combinational.
REQ-028 SHALL hold all other state (PC, A, B, OUT, flags, IR, FSM) in td4x_core.

Verification (N=4, ADDR_W=4, D_VALID=1 unless stated)
REQ-029 SHALL cover carry/zero: MOV A,F; ADD A,1; JNC 0 -> A=0, C=1, Z=1, jump not taken, PC=3.
REQ-030 SHALL cover borrow: MOV A,2; SUB A,3; JZ 0 -> A=F, C=1, Z=0, PC=3.
REQ-031 SHALL cover fetch stall: D_VALID=0 for 3 cycles at PC=5 -> FETCH=1, PC=5, A/B/flags unchanged; proceeds on the first cycle D_VALID=1.
REQ-032 SHALL cover output strobe: OUT Im A -> OUT=A, OUT_STB high exactly one cycle; OUT B with B=6 -> OUT=6 with a second single pulse.
REQ-033 SHALL cover wrap: NOP at PC=F -> next FETCH at A=0.
REQ-034 SHALL cover halt/reset: HLT at PC=7 -> HALTED=1, FETCH=0, PC=7 held for 10 cycles; CLR pulse -> PC=0, all registers 0, FETCH=1 the next cycle.
